// File: rtl/pixel_reg_arbiter.sv
// ============================================================================
// Module   : pixel_reg_arbiter
// Purpose  : Round-robin arbiter loading one shared capture register,
//            drained downstream through a valid/ready handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pixel_reg_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_REQ-1:0]                  req,
  input  logic [N_REQ*DATA_W-1:0]           din,
  output logic [N_REQ-1:0]                  gnt,
  output logic [DATA_W-1:0]                 q,
  output logic [$clog2(N_REQ)-1:0]          q_src,
  output logic                              q_valid,
  input  logic                              q_ready
);

  localparam int SRC_W = $clog2(N_REQ);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    data_q,  data_d;
  logic [SRC_W-1:0]     src_q,   src_d;
  logic [N_REQ-1:0]     gnt_q,   gnt_d;
  logic [SRC_W-1:0]     ptr_q,   ptr_d;

  logic [DATA_W-1:0]    din_arr [N_REQ];
  logic [N_REQ-1:0]     elig;
  logic                 win_found;
  logic [SRC_W-1:0]     win_idx;
  logic                 load;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign din_arr[gi] = din[gi*DATA_W +: DATA_W];
  end

  // A requester still seeing its grant pulse is not eligible this cycle.
  assign elig = req & ~gnt_q;

  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(idx);
      end
    end
  end

  assign load = win_found && ((state_q == IDLE) || q_ready);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    gnt_d   = '0;
    ptr_d   = ptr_q;

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!load && q_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      data_d = din_arr[win_idx];
      src_d  = win_idx;
      gnt_d  = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
      ptr_d  = (win_idx == SRC_W'(N_REQ-1)) ? '0 : win_idx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      src_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign q_src   = src_q;
  assign q_valid = (state_q == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_pixel_reg_arbiter.sv
// ============================================================================
// Module   : tb_pixel_reg_arbiter
// Purpose  : Vector table plus directed sequences for pixel_reg_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pixel_reg_arbiter;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] din;
    logic        rdy;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [1:0]  src;
    logic        vld;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] din = '0;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  q_src;
  logic        q_valid;
  logic        q_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  vec_t exp_queue [$];
  vec_t vecs [16];

  pixel_reg_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .q       (q),
    .q_src   (q_src),
    .q_valid (q_valid),
    .q_ready (q_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    reset   = v.rst_n;
    req     = v.req;
    din     = v.din;
    q_ready = v.rdy;
    exp_queue.push_back(v);
    @(posedge clk);
    #1;
    if (exp_queue.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
    end else begin
      e = exp_queue.pop_front();
      chk({tag, ".gnt"},   32'(gnt),     32'(e.gnt));
      chk({tag, ".q"},     32'(q),       32'(e.q));
      chk({tag, ".src"},   32'(q_src),   32'(e.src));
      chk({tag, ".valid"}, 32'(q_valid), 32'(e.vld));
    end
  endtask

  function automatic vec_t mk(input logic rst_n, input logic [3:0] r, input logic [31:0] d,
                              input logic rdy, input logic [3:0] g, input logic [7:0] qq,
                              input logic [1:0] s, input logic v);
    vec_t t;
    t.rst_n = rst_n; t.req = r; t.din = d; t.rdy = rdy;
    t.gnt = g; t.q = qq; t.src = s; t.vld = v;
    return t;
  endfunction

  initial begin
    // reset, release, single requester, wrap, then round-robin from a fresh reset
    vecs[0]  = mk(0, 4'b1111, 32'h44332211, 1, 4'b0000, 8'h00, 2'd0, 0);
    vecs[1]  = mk(0, 4'b1111, 32'h44332211, 1, 4'b0000, 8'h00, 2'd0, 0);
    vecs[2]  = mk(1, 4'b1111, 32'h44332211, 1, 4'b0001, 8'h11, 2'd0, 1);
    vecs[3]  = mk(1, 4'b0000, 32'h44332211, 1, 4'b0000, 8'h11, 2'd0, 0);
    vecs[4]  = mk(1, 4'b0100, 32'h44A52211, 1, 4'b0100, 8'hA5, 2'd2, 1);
    vecs[5]  = mk(1, 4'b0000, 32'h44A52211, 1, 4'b0000, 8'hA5, 2'd2, 0);
    vecs[6]  = mk(1, 4'b1001, 32'hDDA522C0, 1, 4'b1000, 8'hDD, 2'd3, 1);
    vecs[7]  = mk(1, 4'b1001, 32'hDDA522C0, 1, 4'b0001, 8'hC0, 2'd0, 1);
    vecs[8]  = mk(1, 4'b0000, 32'hDDA522C0, 1, 4'b0000, 8'hC0, 2'd0, 0);
    vecs[9]  = mk(0, 4'b0000, 32'h00000000, 1, 4'b0000, 8'h00, 2'd0, 0);
    vecs[10] = mk(1, 4'b1111, 32'h43424140, 1, 4'b0001, 8'h40, 2'd0, 1);
    vecs[11] = mk(1, 4'b1111, 32'h53525150, 1, 4'b0010, 8'h51, 2'd1, 1);
    vecs[12] = mk(1, 4'b1111, 32'h63626160, 1, 4'b0100, 8'h62, 2'd2, 1);
    vecs[13] = mk(1, 4'b1111, 32'h73727170, 1, 4'b1000, 8'h73, 2'd3, 1);
    vecs[14] = mk(1, 4'b1111, 32'h83828180, 1, 4'b0001, 8'h80, 2'd0, 1);
    vecs[15] = mk(1, 4'b0000, 32'h83828180, 1, 4'b0000, 8'h80, 2'd0, 0);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // backpressure: 3C from req1 held while req3 waits (pointer is at 1 here)
    step(mk(1, 4'b0010, 32'h77003C00, 1, 4'b0010, 8'h3C, 2'd1, 1), "bp_load");
    for (int i = 0; i < 5; i++) begin
      step(mk(1, 4'b1000, 32'h77003C00, 0, 4'b0000, 8'h3C, 2'd1, 1), $sformatf("bp_hold%0d", i));
    end
    step(mk(1, 4'b1000, 32'h77003C00, 1, 4'b1000, 8'h77, 2'd3, 1), "bp_release");
    step(mk(1, 4'b0000, 32'h77003C00, 1, 4'b0000, 8'h77, 2'd3, 0), "bp_drain");

    // reset while holding an unaccepted word, then confirm the pointer restarted at 0
    step(mk(1, 4'b0001, 32'h000000FF, 0, 4'b0001, 8'hFF, 2'd0, 1), "rm_load");
    step(mk(1, 4'b0000, 32'h000000FF, 0, 4'b0000, 8'hFF, 2'd0, 1), "rm_hold");
    step(mk(0, 4'b0000, 32'h000000FF, 1, 4'b0000, 8'h00, 2'd0, 0), "rm_reset");
    step(mk(1, 4'b0011, 32'h00005A96, 1, 4'b0001, 8'h96, 2'd0, 1), "rm_ptr0");
    step(mk(1, 4'b0000, 32'h00005A96, 1, 4'b0000, 8'h96, 2'd0, 0), "rm_drain");

    chk("scoreboard_empty", 32'(exp_queue.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pixel_reg_arbiter.md
# pixel_reg_arbiter

Round-robin arbiter and sequencer for a shared DATA_W-bit capture register: a bank of D flip-flops that holds one pixel/word at a time. Up to N_REQ upstream requesters compete for the register. The block grants one per transfer, loads the winner's data, and holds it with a valid/ready handshake until the downstream consumer accepts it. It sits between pixel-source stages and a single downstream processing stage in the FPGA image pipeline.

## Interface
- N_REQ, 4, number of requesters (≥2)
- DATA_W, 8, width of the shared register
- SRC_W, $clog2(N_REQ), width of source index (derived, not overridable)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk, 0 = reset
- req  in  N_REQ  per-requester transfer request, level
- din  in  N_REQ*DATA_W  requester data; requester i occupies bits [i*DATA_W +: DATA_W]
- gnt  out  N_REQ  one-hot grant pulse, registered
- q  out  DATA_W  shared register contents, registered
- q_src  out  SRC_W  index of the requester that loaded q, registered
- q_valid  out  1  q holds an unaccepted word
- q_ready  in  1  downstream accepts q when q_valid && q_ready at a rising edge

## Operation
- States: IDLE (q_valid=0) and HOLD (q_valid=1). The state is fully encoded by q_valid.
- Reset (reset=0 at an edge): q=0, q_src=0, q_valid=0, gnt=0, round-robin pointer ptr=0, state IDLE. Reset overrides every other event. A word held mid-transfer is discarded, not delivered.
- Eligible set E = req & ~gnt. The requester currently seeing its grant pulse is excluded that cycle.
- Winner w = first set bit of E searching upward from ptr, wrapping N_REQ-1 → 0.
- Load condition L = (E != 0) && (!q_valid || q_ready).
- On an edge with L:
  - q ← din[w]
  - q_src ← w
  - q_valid ← 1
  - gnt ← onehot(w)
  - ptr ← (w+1) mod N_REQ
- On an edge without L:
  - gnt ← 0
  - if q_valid && q_ready then q_valid ← 0
  - q, q_src and ptr hold.
- HOLD with q_ready=0: q, q_src and q_valid are stable. Requests wait and nothing is lost or overwritten.
- Accept and load in the same edge (back-to-back) is legal, giving full throughput of one word per cycle.
- Requester protocol: din[i] must be stable while req[i]=1. If the requester has no further word, it deasserts req[i] in the cycle gnt[i]=1. If req[i] is still high in the following cycle, that is a new request.
- A requester cannot win twice in a row while any other requester is eligible. Worst-case wait is N_REQ-1 transfers.
- ptr after wrap: w=N_REQ-1 → ptr=0.

## Timing
- Request to data: req sampled at edge k, no higher-priority contention, register free → q, q_valid and gnt are visible after edge k (latency 1).
- gnt is exactly one cycle wide per transfer. It coincides with the first cycle q_valid=1 for that word.
- Accept: q_valid falls after the edge where q_valid && q_ready, unless a new load occurs at the same edge.
- No combinational path from req, din or q_ready to any output.

## Test plan
- Reset: drive reset=0 for 2 cycles with req=4'b1111 → q=0, q_valid=0, gnt=0, q_src=0. Release reset → first grant goes to req0 (gnt=4'b0001).
- Single requester: req=4'b0100, din[2]=8'hA5, q_ready=1 → after 1 edge q=8'hA5, q_src=2, gnt=4'b0100 for 1 cycle. Drop req → q_valid=0 after the next edge.
- Round-robin fairness: req=4'b1111 held, q_ready=1, each requester refreshing data → grant order 0,1,2,3,0, one per cycle, with q_src matching each grant.
- Backpressure: load 8'h3C from req1, hold q_ready=0 for 5 cycles while req3 is active → q stays 8'h3C with q_valid=1 and gnt=0. Raise q_ready → next edge loads req3's data with gnt=4'b1000.
- Wrap and priority: ptr at 3 after a grant to req2, req=4'b1001 → req3 wins first, then req0.
- Reset mid-transfer: HOLD with q=8'hFF and q_ready=0, then reset=0 for 1 cycle → q_valid=0 and q=0. The word is never accepted and ptr=0.
